// File: rtl/alu_step_ctrl_if.sv
// ---------------------------------------------------------------------------
// alu_step_ctrl_if
// Bundles the switch/button inputs, the ALU operand/result bus and the
// display-side outputs of the step sequencer.
//   slave  : the sequencer (alu_step_ctrl) side
//   master : the board/ALU/display side that surrounds it
// Signals:
//   step      debounced, synchronized step button (level)
//   clr       synchronous abort/clear (level)
//   sw        switch word
//   op_a/op_b operands to the ALU
//   op_sel    opcode to the ALU
//   alu_out   ALU result
//   alu_flags ALU flags {ZF,CF,OF,SF}
//   result    captured result for the display
//   flags     captured flags {ZF,CF,OF,SF}
//   state     current sequencer state encoding
//   done      one-cycle pulse on capture
// ---------------------------------------------------------------------------
interface alu_step_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
);
  logic             step;
  logic             clr;
  logic [WIDTH-1:0] sw;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [OPW-1:0]   op_sel;
  logic [WIDTH-1:0] alu_out;
  logic [3:0]       alu_flags;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic [2:0]       state;
  logic             done;

  modport slave (
    input  step, clr, sw, alu_out, alu_flags,
    output op_a, op_b, op_sel, result, flags, state, done
  );

  modport master (
    output step, clr, sw, alu_out, alu_flags,
    input  op_a, op_b, op_sel, result, flags, state, done
  );
endinterface

// File: rtl/alu_step_ctrl.sv
// ---------------------------------------------------------------------------
// alu_step_ctrl
// Step-button sequencer around the ALU. Successive step presses latch the
// switch word as operand A, operand B and then the opcode; after
// EXEC_CYCLES clock edges the ALU result and flags are captured for the
// display and a one-cycle done pulse is raised.
//
// Ports:
//   clk  system clock
//   rst  asynchronous reset, active-high
//   bus  alu_step_ctrl_if.slave (step, clr, sw, alu_out, alu_flags in;
//        op_a, op_b, op_sel, result, flags, state, done out)
//
// Configuration:
//   ALU_CHAIN_EN  when defined, a step press in DONE loads the previous
//                 result as operand A instead of the switch word, so results
//                 can be chained accumulator-style. Undefined by default.
// ---------------------------------------------------------------------------
module alu_step_ctrl #(
  parameter int WIDTH       = 32,
  parameter int OPW         = 4,
  parameter int EXEC_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  alu_step_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GOT_A = 3'd1,
    S_GOT_B = 3'd2,
    S_EXEC  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Counter preload: EXEC_CYCLES-1 further edges are spent counting down,
  // the edge that sees cnt==0 performs the capture.
  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_e           state_q,    state_d;
  logic             step_dly_q, step_dly_d;
  logic [3:0]       cnt_q,      cnt_d;
  logic [WIDTH-1:0] op_a_q,     op_a_d;
  logic [WIDTH-1:0] op_b_q,     op_b_d;
  logic [OPW-1:0]   op_sel_q,   op_sel_d;
  logic [WIDTH-1:0] result_q,   result_d;
  logic [3:0]       flags_q,    flags_d;
  logic             done_q,     done_d;
  logic             step_pulse;

  // Rising edge of the (already debounced) step level: one pulse per press.
  assign step_pulse = bus.step & ~step_dly_q;

  // Next-state and datapath update logic.
  always_comb begin
    state_d    = state_q;
    step_dly_d = bus.step;
    cnt_d      = cnt_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_sel_d   = op_sel_q;
    result_d   = result_q;
    flags_d    = flags_q;
    done_d     = 1'b0;

    if (bus.clr) begin
      // Abort: operands and sequencing are cleared, displayed result kept.
      state_d  = S_IDLE;
      cnt_d    = 4'd0;
      op_a_d   = '0;
      op_b_d   = '0;
      op_sel_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (step_pulse) begin
            op_a_d  = bus.sw;
            state_d = S_GOT_A;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_GOT_A: begin
          if (step_pulse) begin
            op_b_d  = bus.sw;
            state_d = S_GOT_B;
          end else begin
            state_d = S_GOT_A;
          end
        end
        S_GOT_B: begin
          if (step_pulse) begin
            op_sel_d = bus.sw[OPW-1:0];
            cnt_d    = CNT_INIT;
            state_d  = S_EXEC;
          end else begin
            state_d = S_GOT_B;
          end
        end
        S_EXEC: begin
          // Step presses are ignored while the ALU settles.
          if (cnt_q != 4'd0) begin
            cnt_d   = cnt_q - 4'd1;
            state_d = S_EXEC;
          end else begin
            result_d = bus.alu_out;
            flags_d  = bus.alu_flags;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end
        end
        S_DONE: begin
          if (step_pulse) begin
`ifdef ALU_CHAIN_EN
            op_a_d = result_q;
`else
            op_a_d = bus.sw;
`endif
            state_d = S_GOT_A;
          end else begin
            state_d = S_DONE;
          end
        end
        default: begin
          // Unused encodings fall back to IDLE on the next edge.
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      step_dly_q <= 1'b0;
      cnt_q      <= 4'd0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_sel_q   <= '0;
      result_q   <= '0;
      flags_q    <= 4'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_dly_q <= step_dly_d;
      cnt_q      <= cnt_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_sel_q   <= op_sel_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
      done_q     <= done_d;
    end
  end

  assign bus.op_a   = op_a_q;
  assign bus.op_b   = op_b_q;
  assign bus.op_sel = op_sel_q;
  assign bus.result = result_q;
  assign bus.flags  = flags_q;
  assign bus.state  = state_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_alu_step_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_step_ctrl
// Directed bench for alu_step_ctrl. Two instances share the board inputs:
// u_dut2 (EXEC_CYCLES=2) and u_dut4 (EXEC_CYCLES=4). Each has its own stub
// ALU: opcode 0 is add with {ZF,CF,OF,SF}, other opcodes XOR with no flags.
// ---------------------------------------------------------------------------
module tb_alu_step_ctrl;

  logic        clk;
  logic        rst;
  logic        step;
  logic        clr;
  logic [31:0] sw;
  int          errors;
  int          checks;

  alu_step_ctrl_if #(.WIDTH(32), .OPW(4)) bus2 ();
  alu_step_ctrl_if #(.WIDTH(32), .OPW(4)) bus4 ();

  alu_step_ctrl #(.WIDTH(32), .OPW(4), .EXEC_CYCLES(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  alu_step_ctrl #(.WIDTH(32), .OPW(4), .EXEC_CYCLES(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  assign bus2.step = step;
  assign bus2.clr  = clr;
  assign bus2.sw   = sw;
  assign bus4.step = step;
  assign bus4.clr  = clr;
  assign bus4.sw   = sw;

  function automatic logic [35:0] stub_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op);
    logic [32:0] sum;
    logic        zf, cf, of, sf;
    if (op == 4'd0) begin
      sum = {1'b0, a} + {1'b0, b};
      zf  = (sum[31:0] == 32'd0);
      cf  = sum[32];
      of  = (a[31] == b[31]) && (sum[31] != a[31]);
      sf  = sum[31];
      return {sum[31:0], zf, cf, of, sf};
    end else begin
      return {a ^ b, 4'd0};
    end
  endfunction

  always_comb begin
    {bus2.alu_out, bus2.alu_flags} = stub_alu(bus2.op_a, bus2.op_b, bus2.op_sel);
    {bus4.alu_out, bus4.alu_flags} = stub_alu(bus4.op_a, bus4.op_b, bus4.op_sel);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic press(input logic [31:0] val);
    @(negedge clk);
    sw   = val;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (bus2.state !== 3'd0 || bus2.op_a !== 32'd0 || bus2.op_b !== 32'd0 ||
        bus2.op_sel !== 4'd0 || bus2.result !== 32'd0 || bus2.flags !== 4'd0 ||
        bus2.done !== 1'b0) begin
      $display("FAIL reset_values: state=%0d op_a=%h op_b=%h op_sel=%h result=%h flags=%b done=%b, want all zero",
               bus2.state, bus2.op_a, bus2.op_b, bus2.op_sel, bus2.result, bus2.flags, bus2.done);
      errors++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus2.state !== 3'd0) begin
      $display("FAIL reset_idle: state=%0d want 0", bus2.state);
      errors++;
    end
  endtask

  task automatic test_basic();
    press(32'h0000_0005);
    checks++;
    if (bus2.state !== 3'd1 || bus2.op_a !== 32'h5) begin
      $display("FAIL basic_a: state=%0d op_a=%h want 1/00000005", bus2.state, bus2.op_a);
      errors++;
    end
    press(32'h0000_0003);
    checks++;
    if (bus2.state !== 3'd2 || bus2.op_b !== 32'h3) begin
      $display("FAIL basic_b: state=%0d op_b=%h want 2/00000003", bus2.state, bus2.op_b);
      errors++;
    end
    press(32'h0000_0000);
    checks++;
    if (bus2.state !== 3'd3 || bus2.op_sel !== 4'd0 || bus2.done !== 1'b0) begin
      $display("FAIL basic_exec1: state=%0d op_sel=%h done=%b want 3/0/0", bus2.state, bus2.op_sel, bus2.done);
      errors++;
    end
    @(negedge clk);
    checks++;
    if (bus2.state !== 3'd3 || bus2.done !== 1'b0 || bus2.result !== 32'd0) begin
      $display("FAIL basic_exec2: state=%0d done=%b result=%h want 3/0/00000000", bus2.state, bus2.done, bus2.result);
      errors++;
    end
    @(negedge clk);
    checks++;
    if (bus2.state !== 3'd4 || bus2.done !== 1'b1 || bus2.result !== 32'h8 || bus2.flags !== 4'b0000) begin
      $display("FAIL basic_capture: state=%0d done=%b result=%h flags=%b want 4/1/00000008/0000",
               bus2.state, bus2.done, bus2.result, bus2.flags);
      errors++;
    end
    @(negedge clk);
    checks++;
    if (bus2.state !== 3'd4 || bus2.done !== 1'b0 || bus2.result !== 32'h8) begin
      $display("FAIL basic_done_pulse: state=%0d done=%b result=%h want 4/0/00000008", bus2.state, bus2.done, bus2.result);
      errors++;
    end
  endtask

  task automatic test_chain();
    logic [31:0] exp_a;
    logic [31:0] exp_r;
`ifdef ALU_CHAIN_EN
    exp_a = 32'h8;
    exp_r = 32'hA;
`else
    exp_a = 32'h5;
    exp_r = 32'h7;
`endif
    press(32'h0000_0005);
    checks++;
    if (bus2.state !== 3'd1 || bus2.op_a !== exp_a) begin
      $display("FAIL chain_op_a: state=%0d op_a=%h want 1/%h", bus2.state, bus2.op_a, exp_a);
      errors++;
    end
    press(32'h0000_0002);
    press(32'h0000_0000);
    repeat (2) @(negedge clk);
    checks++;
    if (bus2.done !== 1'b1 || bus2.result !== exp_r) begin
      $display("FAIL chain_result: done=%b result=%h want 1/%h", bus2.done, bus2.result, exp_r);
      errors++;
    end
  endtask

  task automatic test_clr_keeps_result();
    logic [31:0] exp_r;
`ifdef ALU_CHAIN_EN
    exp_r = 32'hA;
`else
    exp_r = 32'h7;
`endif
    do_clr();
    checks++;
    if (bus2.state !== 3'd0 || bus2.op_a !== 32'd0 || bus2.op_b !== 32'd0 ||
        bus2.op_sel !== 4'd0 || bus2.result !== exp_r) begin
      $display("FAIL clr_idle: state=%0d op_a=%h op_b=%h op_sel=%h result=%h want 0/0/0/0/%h",
               bus2.state, bus2.op_a, bus2.op_b, bus2.op_sel, bus2.result, exp_r);
      errors++;
    end
  endtask

  task automatic test_flags();
    press(32'hFFFF_FFFF);
    press(32'h0000_0001);
    press(32'h0000_0000);
    repeat (2) @(negedge clk);
    checks++;
    if (bus2.done !== 1'b1 || bus2.result !== 32'd0 || bus2.flags !== 4'b1100) begin
      $display("FAIL flags_carry: done=%b result=%h flags=%b want 1/00000000/1100",
               bus2.done, bus2.result, bus2.flags);
      errors++;
    end
  endtask

  task automatic test_stuck_step();
    do_clr();
    @(negedge clk);
    sw   = 32'h0000_0011;
    step = 1'b1;
    @(negedge clk);
    sw = 32'h0000_0099;
    repeat (9) @(negedge clk);
    checks++;
    if (bus2.state !== 3'd1 || bus2.op_a !== 32'h11 || bus2.op_b !== 32'd0) begin
      $display("FAIL stuck_step: state=%0d op_a=%h op_b=%h want 1/00000011/00000000",
               bus2.state, bus2.op_a, bus2.op_b);
      errors++;
    end
    step = 1'b0;
    press(32'h0000_0022);
    press(32'h0000_0000);
    // Press during EXEC must be ignored.
    sw   = 32'h0000_0077;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    checks++;
    if (bus2.state !== 3'd3 || bus2.op_a !== 32'h11) begin
      $display("FAIL exec_ignore: state=%0d op_a=%h want 3/00000011", bus2.state, bus2.op_a);
      errors++;
    end
    @(negedge clk);
    checks++;
    if (bus2.state !== 3'd4 || bus2.done !== 1'b1 || bus2.result !== 32'h33) begin
      $display("FAIL exec_capture: state=%0d done=%b result=%h want 4/1/00000033",
               bus2.state, bus2.done, bus2.result);
      errors++;
    end
  endtask

  task automatic test_abort();
    logic saw_done;
    do_clr();
    press(32'h0000_0005);
    press(32'h0000_0003);
    press(32'h0000_0000);
    repeat (5) @(negedge clk);
    checks++;
    if (bus4.state !== 3'd4 || bus4.result !== 32'h8) begin
      $display("FAIL abort_setup: state=%0d result=%h want 4/00000008", bus4.state, bus4.result);
      errors++;
    end
    do_clr();
    press(32'h0000_0010);
    press(32'h0000_0020);
    press(32'h0000_0000);
    checks++;
    if (bus4.state !== 3'd3) begin
      $display("FAIL abort_in_exec: state=%0d want 3", bus4.state);
      errors++;
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (bus4.state !== 3'd0 || bus4.op_a !== 32'd0 || bus4.op_b !== 32'd0 ||
        bus4.op_sel !== 4'd0 || bus4.done !== 1'b0 || bus4.result !== 32'h8) begin
      $display("FAIL abort_clear: state=%0d op_a=%h op_b=%h op_sel=%h done=%b result=%h want 0/0/0/0/0/00000008",
               bus4.state, bus4.op_a, bus4.op_b, bus4.op_sel, bus4.done, bus4.result);
      errors++;
    end
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus4.done !== 1'b0 || bus4.state !== 3'd0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0 || bus4.result !== 32'h8) begin
      $display("FAIL abort_no_capture: activity=%b result=%h want 0/00000008", saw_done, bus4.result);
      errors++;
    end
  endtask

  task automatic test_reset_mid();
    do_clr();
    press(32'h0000_0007);
    press(32'h0000_0009);
    checks++;
    if (bus2.state !== 3'd2) begin
      $display("FAIL rst_mid_setup: state=%0d want 2", bus2.state);
      errors++;
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus2.state !== 3'd0 || bus2.op_a !== 32'd0 || bus2.op_b !== 32'd0 ||
        bus2.result !== 32'd0 || bus2.flags !== 4'd0 || bus4.result !== 32'd0) begin
      $display("FAIL rst_mid_async: state=%0d op_a=%h op_b=%h result=%h flags=%b result4=%h want all zero",
               bus2.state, bus2.op_a, bus2.op_b, bus2.result, bus2.flags, bus4.result);
      errors++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus2.state !== 3'd0 || bus2.op_a !== 32'd0) begin
      $display("FAIL rst_mid_wait: state=%0d op_a=%h want 0/00000000", bus2.state, bus2.op_a);
      errors++;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    step   = 1'b0;
    clr    = 1'b0;
    sw     = 32'd0;
    test_reset();
    test_basic();
    test_chain();
    test_clr_keeps_result();
    test_flags();
    test_stuck_step();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
